pwm_capture: RTL and testbench

Bus-readable PWM input-capture peripheral: it measures the high time and period of an external pulse train, such as servo position feedback or an RC receiver channel. It is the input-side counterpart of the servo PWM generator and sits on the same APB3-style peripheral bus. Measurements are counted in pclk cycles and published as an atomic high/period pair once per input period. A one-cycle irq pulse accompanies each published measurement.

---
 rtl/pwm_capture_if.sv | 28 ++
 rtl/pwm_capture.sv | 170 +++++++++++++++++
 tb/tb_pwm_capture.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: APB3-style register bus bundle
// for the PWM input-capture peripheral.
interface pwm_capture_if;
  logic        bus_write_en;
  logic        bus_read_en;
  logic        capture_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;

  modport master (
    output bus_write_en,
    output bus_read_en,
    output capture_en,
    output bus_addr,
    output bus_write_data,
    input  bus_read_data
  );

  modport slave (
    input  bus_write_en,
    input  bus_read_en,
    input  capture_en,
    input  bus_addr,
    input  bus_write_data,
    output bus_read_data
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of pwm_in
// in pclk cycles and publishes them as an atomic pair.
module pwm_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd1000000
) (
  input  logic         pclk,
  input  logic         nreset,
  pwm_capture_if.slave bus,
  input  logic         pwm_in,
  output logic         irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [1:0]             r_state;
  logic [31:0]            r_cnt;
  logic [31:0]            r_pend;
  logic [31:0]            r_high;
  logic [31:0]            r_period;
  logic                   r_valid;
  logic                   r_new;
  logic                   r_to;
  logic                   r_ovr;
  logic                   r_en;
  logic                   r_irq;

  logic        w_s;
  logic        w_rise;
  logic        w_fall;
  logic        w_wr;
  logic        w_wr_stat;
  logic        w_wr_ctrl;
  logic        w_clr_new;
  logic        w_clr_to;
  logic        w_clr_ovr;
  logic        w_publish;
  logic        w_timeout;
  logic        w_sat;
  logic [31:0] w_cnt_inc;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  assign w_wr      = bus.bus_write_en & bus.capture_en;
  assign w_wr_stat = w_wr & (bus.bus_addr[3:2] == 2'd2);
  assign w_wr_ctrl = w_wr & (bus.bus_addr[3:2] == 2'd3);
  assign w_clr_new = w_wr_stat & bus.bus_write_data[1];
  assign w_clr_to  = w_wr_stat & bus.bus_write_data[2];
  assign w_clr_ovr = w_wr_stat & bus.bus_write_data[3];

  assign w_sat     = (r_cnt == TIMEOUT);
  assign w_cnt_inc = w_sat ? r_cnt : r_cnt + 32'd1;

  assign w_publish = r_en & (r_state == ST_LOW) & w_rise;
  assign w_timeout = r_en & (r_state != ST_IDLE) & w_sat
                   & ~w_rise & ~w_fall;

  assign w_unused = ^{bus.bus_addr[7:4], bus.bus_addr[1:0],
                      bus.bus_write_data[31:4]};

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= w_s;
    end
  end

  // enable low overrides every state and drops partial work
  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else if (!r_en) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else if (w_timeout) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_HIGH;
            r_cnt   <= 32'd1;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_state <= ST_LOW;
            r_pend  <= r_cnt;
            r_cnt   <= w_cnt_inc;
          end else if (w_rise) begin
            r_cnt <= 32'd1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_state <= ST_HIGH;
            r_cnt   <= 32'd1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      r_high   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_new    <= 1'b0;
      r_to     <= 1'b0;
      r_ovr    <= 1'b0;
      r_en     <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= w_publish;
      if (w_publish) begin
        r_high   <= r_pend;
        r_period <= r_cnt;
        r_valid  <= 1'b1;
      end else if (w_timeout) begin
        r_valid <= 1'b0;
      end
      // set wins over a same-cycle W1C
      r_new <= w_publish | (r_new & ~w_clr_new);
      r_ovr <= (w_publish & r_new & ~w_clr_new)
             | (r_ovr & ~w_clr_ovr);
      r_to  <= w_timeout | (r_to & ~w_clr_to);
      if (w_wr_ctrl) r_en <= bus.bus_write_data[0];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.bus_read_en & bus.capture_en) begin
      case (bus.bus_addr[3:2])
        2'd0:    w_rdata = r_high;
        2'd1:    w_rdata = r_period;
        2'd2:    w_rdata = {28'd0, r_ovr, r_to, r_new, r_valid};
        default: w_rdata = {31'd0, r_en};
      endcase
    end
  end

  assign bus.bus_read_data = w_rdata;
  assign irq = r_irq;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed + random PWM trains checked
// against an edge-timestamp model of the capture rules.
`timescale 1ns/100ps
module tb_pwm_capture;

  localparam logic [31:0] TO = 32'd2000;

  logic pclk;
  logic nreset;
  logic pwm_in;
  logic irq;

  pwm_capture_if bus ();

  pwm_capture #(
    .SYNC_STAGES (2),
    .TIMEOUT     (TO)
  ) dut (
    .pclk   (pclk),
    .nreset (nreset),
    .bus    (bus),
    .pwm_in (pwm_in),
    .irq    (irq)
  );

  initial pclk = 1'b0;
  always #10 pclk = ~pclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int irq_cnt = 0;
  logic irq_prev = 1'b0;
  logic irq_consec = 1'b0;

  always @(negedge pclk) begin
    if (!nreset) begin
      irq_cnt  <= 0;
      irq_prev <= 1'b0;
    end else begin
      if (irq) irq_cnt <= irq_cnt + 1;
      if (irq && irq_prev) irq_consec <= 1'b1;
      irq_prev <= irq;
    end
  end

  // model: timestamps of driven edges, in cycles
  logic        m_en, m_active;
  logic        m_valid, m_new, m_to, m_ovr;
  logic [31:0] m_high, m_period;
  int          m_rise_t, m_fall_t, m_irqs;

  task automatic model_reset();
    m_en = 0; m_active = 0;
    m_valid = 0; m_new = 0; m_to = 0; m_ovr = 0;
    m_high = 0; m_period = 0;
    m_rise_t = 0; m_fall_t = 0; m_irqs = 0;
  endtask

  task automatic model_rise(input bit clr_same);
    if (m_en) begin
      if (m_active) begin
        if (m_new && !clr_same) m_ovr = 1;
        m_new = 1;
        m_valid = 1;
        m_high = 32'(m_fall_t - m_rise_t);
        m_period = 32'(cyc - m_rise_t);
        m_irqs++;
      end
      m_active = 1;
      m_rise_t = cyc;
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    cyc++;
    if (m_active && (cyc - m_rise_t) > int'(TO)) begin
      m_to = 1; m_valid = 0; m_active = 0;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.bus_addr = {4'd0, a, 2'd0};
    bus.bus_read_en = 1'b1;
    bus.capture_en = 1'b1;
    #1;
    d = bus.bus_read_data;
    bus.bus_read_en = 1'b0;
    bus.capture_en = 1'b0;
  endtask

  task automatic wr_raw(input logic [1:0] a, input logic [31:0] d);
    bus.bus_addr = {4'd0, a, 2'd0};
    bus.bus_write_data = d;
    bus.bus_write_en = 1'b1;
    bus.capture_en = 1'b1;
    tick();
    bus.bus_write_en = 1'b0;
    bus.capture_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_raw(a, d);
    if (a == 2'd2) begin
      if (d[1]) m_new = 0;
      if (d[2]) m_to = 0;
      if (d[3]) m_ovr = 0;
    end
    if (a == 2'd3) begin
      m_en = d[0];
      if (!m_en) m_active = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    rd(2'd0, v); chk({tag, ".high"}, v, m_high);
    rd(2'd1, v); chk({tag, ".period"}, v, m_period);
    rd(2'd2, v);
    chk({tag, ".status"}, v, {28'd0, m_ovr, m_to, m_new, m_valid});
    rd(2'd3, v); chk({tag, ".ctrl"}, v, {31'd0, m_en});
    chk({tag, ".irqs"}, 32'(irq_cnt), 32'(m_irqs));
  endtask

  // mode 1: clear new mid-high, 2: clear new in publish cycle,
  // 3: disable mid-high
  task automatic period(input int h, input int l, input int mode,
                        input string tag);
    int c;
    pwm_in = 1'b1;
    model_rise(mode == 2);
    c = 0;
    if (mode == 2) begin
      tick(); tick();
      wr_raw(2'd2, 32'h2);
      c = 3;
    end
    while (c < 4) begin tick(); c++; end
    check_all(tag);
    if (mode == 1) begin wr(2'd2, 32'h2); c++; end
    if (mode == 3) begin wr(2'd3, 32'h0); c++; end
    while (c < h) begin tick(); c++; end
    pwm_in = 1'b0;
    if (m_active) m_fall_t = cyc;
    for (int i = 0; i < l; i++) tick();
  endtask

  logic [31:0] v;
  logic [31:0] sv_h, sv_p;
  int          sv_irq;

  initial begin
    bus.bus_write_en = 1'b0;
    bus.bus_read_en = 1'b0;
    bus.capture_en = 1'b0;
    bus.bus_addr = '0;
    bus.bus_write_data = '0;
    pwm_in = 1'b0;
    nreset = 1'b0;
    model_reset();
    repeat (3) tick();
    nreset = 1'b1;
    tick();
    check_all("rst");
    chk("rst.irq", {31'd0, irq}, 32'd0);

    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v); chk("ctrl_rd", v, 32'h1);
    bus.bus_addr = 8'h0C; bus.bus_read_en = 1'b1;
    #1 chk("rd_gated", bus.bus_read_data, 32'h0);
    bus.bus_read_en = 1'b0;

    period(150, 850, 0, "s0");
    period(150, 850, 0, "s1");
    rd(2'd2, v); chk("s1.st3", v, 32'h3);
    period(150, 850, 0, "s2");
    rd(2'd2, v); chk("ovr.stB", v, 32'hB);
    wr(2'd2, 32'hA);
    rd(2'd2, v); chk("ovr.clr", v, 32'h1);

    period(150, 850, 0, "p0");
    period(150, 850, 2, "pubclr");
    rd(2'd2, v); chk("pubclr.st", v, 32'h3);
    period(300, 700, 1, "d0");
    period(300, 700, 1, "d1");
    rd(2'd0, v); chk("duty.h", v, 32'd300);
    rd(2'd1, v); chk("duty.p", v, 32'd1000);

    for (int i = 0; i < 8; i++)
      period(int'($urandom_range(400, 8)),
             int'($urandom_range(600, 5)),
             int'($urandom_range(2, 0)), "rnd");

    pwm_in = 1'b1;
    model_rise(1'b0);
    sv_h = m_high; sv_p = m_period;
    repeat (3000) tick();
    check_all("to");
    rd(2'd2, v); chk("to.bits", v & 32'h5, 32'h4);
    rd(2'd0, v); chk("to.h", v, sv_h);
    rd(2'd1, v); chk("to.p", v, sv_p);
    pwm_in = 1'b0;
    repeat (50) tick();
    wr(2'd2, 32'h4);
    period(200, 300, 1, "tr0");
    period(200, 300, 1, "tr1");
    check_all("tr2");
    rd(2'd1, v); chk("tr.p", v, 32'd500);

    period(250, 400, 3, "en0");
    sv_irq = m_irqs;
    period(250, 400, 0, "en1");
    wr(2'd3, 32'h1);
    period(250, 400, 0, "en2");
    chk("en.noirq", 32'(irq_cnt), 32'(sv_irq));
    period(250, 400, 0, "en3");
    rd(2'd0, v); chk("en.h", v, 32'd250);
    rd(2'd1, v); chk("en.p", v, 32'd650);

    pwm_in = 1'b1;
    repeat (10) tick();
    #2 nreset = 1'b0;
    model_reset();
    rd(2'd0, v); chk("arst.h", v, 32'd0);
    rd(2'd1, v); chk("arst.p", v, 32'd0);
    rd(2'd2, v); chk("arst.st", v, 32'd0);
    rd(2'd3, v); chk("arst.ctrl", v, 32'd0);
    chk("arst.irq", {31'd0, irq}, 32'd0);
    pwm_in = 1'b0;
    repeat (5) tick();
    nreset = 1'b1;
    tick();
    check_all("post_rst");
    wr(2'd3, 32'h1);
    period(100, 100, 0, "pr0");
    period(100, 100, 0, "pr1");
    period(100, 100, 0, "pr2");
    repeat (10) tick();
    check_all("end");
    chk("irq_consec", {31'd0, irq_consec}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
